// File: rtl/sha_pad_pkg.sv
// Shared types and helpers for the SHA message padder.
// The state enum, block geometry constants and the last-beat pad merge function.
package sha_pad_pkg;

  typedef enum logic [2:0] {
    ST_DATA,
    ST_PAD,
    ST_ZERO,
    ST_LEN_HI,
    ST_LEN_LO
  } pad_state_t;

  localparam int          BLK_WORDS  = 16;
  localparam logic [3:0]  LEN_HI_IDX = 4'd14;
  localparam logic [3:0]  LEN_LO_IDX = 4'd15;
  localparam logic [7:0]  PAD_BYTE   = 8'h80;

  // Operates on a 64-bit MS-justified word so one helper serves both word widths.
  function automatic logic [63:0] pad_merge(input logic [63:0] data, input logic [3:0] nbytes);
    logic [63:0] keep;
    logic [63:0] marker;
    keep   = ~(64'hFFFF_FFFF_FFFF_FFFF >> {nbytes, 3'b000});
    marker = (nbytes >= 4'd8) ? 64'd0 : ({PAD_BYTE, 56'd0} >> {nbytes, 3'b000});
    return (data & keep) | marker;
  endfunction

endpackage

// File: rtl/sha_out_slice.sv
// Single valid/ready register stage; one cycle latency, full throughput.
// Accepts a new word when empty or when the held word is taken; holds it stable while stalled.
module sha_out_slice #(
  parameter int DAT_W = 37
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [DAT_W-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [DAT_W-1:0] out_dat
);

  assign in_rdy = !out_vld || out_rdy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_vld <= 1'b0;
      out_dat <= '0;
    end else if (clr) begin
      out_vld <= 1'b0;
    end else if (in_rdy) begin
      out_vld <= in_vld;
      if (in_vld) out_dat <= in_dat;
    end
  end

endmodule

// File: rtl/sha_msg_padder.sv
// Packs a big-endian message stream into 16-word SHA blocks with hardware padding; 1-cycle latency.
// Input is stalled outside DATA and whenever the output slice is full and not being drained.
module sha_msg_padder
  import sha_pad_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int LEN_W  = 2 * WORD_W,
  localparam int NB      = WORD_W / 8,
  localparam int BYTES_W = $clog2(NB) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               msg_valid,
  output logic               msg_ready,
  input  logic [WORD_W-1:0]  msg_data,
  input  logic               msg_last,
  input  logic [BYTES_W-1:0] msg_bytes,
  output logic               blk_valid,
  input  logic               blk_ready,
  output logic [WORD_W-1:0]  blk_data,
  output logic [3:0]         blk_idx,
  output logic               blk_final
);

  localparam int         CNT_W    = LEN_W - 3;
  localparam logic [3:0] FIT_IDX  = LEN_HI_IDX - 4'd1;
  localparam logic [3:0] LAST_IDX = 4'(BLK_WORDS - 1);

  pad_state_t        state_q;
  logic [3:0]        idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              extra_q, fin_q, run_q;

  logic              ld_vld, ld_rdy, ld_final, load, last_part;
  logic [WORD_W-1:0] ld_dat;
  logic [63:0]       din64, merged64;
  logic [CNT_W-1:0]  cnt_add;
  logic [2*WORD_W-1:0] len_bits;
  pad_state_t        rule_state;
  logic              rule_extra, rule_fin;

  assign last_part = msg_last && (msg_bytes < BYTES_W'(NB));
  assign din64     = 64'(msg_data) << (64 - WORD_W);
  assign merged64  = pad_merge(din64, 4'(msg_bytes));
  assign cnt_add   = last_part ? CNT_W'(msg_bytes) : CNT_W'(NB);
  assign len_bits  = (2*WORD_W)'({cnt_q, 3'b000});

  assign msg_ready = run_q && (state_q == ST_DATA) && ld_rdy;
  assign load      = ld_vld && ld_rdy && !clr;

  // Where to go once the 0x80 word lands at idx_q; fin marks whether following words sit in the last block.
  always_comb begin
    rule_state = ST_ZERO;
    rule_extra = 1'b0;
    rule_fin   = 1'b1;
    if (idx_q == FIT_IDX) begin
      rule_state = ST_LEN_HI;
    end else if (idx_q == LEN_HI_IDX) begin
      rule_extra = 1'b1;
      rule_fin   = 1'b0;
    end
  end

  always_comb begin
    ld_vld   = 1'b0;
    ld_dat   = '0;
    ld_final = fin_q;
    case (state_q)
      ST_DATA: begin
        ld_vld   = run_q && msg_valid;
        ld_dat   = last_part ? WORD_W'(merged64 >> (64 - WORD_W)) : msg_data;
        ld_final = msg_last && (last_part ? (idx_q <= FIT_IDX) : (idx_q < FIT_IDX));
      end
      ST_PAD: begin
        ld_vld   = 1'b1;
        ld_dat   = {PAD_BYTE, {(WORD_W-8){1'b0}}};
        ld_final = (idx_q <= FIT_IDX);
      end
      ST_ZERO:   ld_vld = 1'b1;
      ST_LEN_HI: begin
        ld_vld = 1'b1;
        ld_dat = len_bits[2*WORD_W-1 -: WORD_W];
      end
      ST_LEN_LO: begin
        ld_vld = 1'b1;
        ld_dat = len_bits[WORD_W-1:0];
      end
      default: ld_vld = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_DATA;
      idx_q   <= '0;
      cnt_q   <= '0;
      extra_q <= 1'b0;
      fin_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (clr) begin
        state_q <= ST_DATA;
        idx_q   <= '0;
        cnt_q   <= '0;
        extra_q <= 1'b0;
        fin_q   <= 1'b0;
      end else if (load) begin
        idx_q <= idx_q + 4'd1;
        case (state_q)
          ST_DATA: begin
            cnt_q <= cnt_q + cnt_add;
            if (last_part) begin
              state_q <= rule_state;
              extra_q <= rule_extra;
              fin_q   <= rule_fin;
            end else if (msg_last) begin
              state_q <= ST_PAD;
            end
          end
          ST_PAD: begin
            state_q <= rule_state;
            extra_q <= rule_extra;
            fin_q   <= rule_fin;
          end
          ST_ZERO: begin
            // Wrapping into a fresh block: the length always follows in this one.
            if (idx_q == LAST_IDX) begin
              extra_q <= 1'b0;
              fin_q   <= 1'b1;
            end
            if (!extra_q && idx_q == FIT_IDX) state_q <= ST_LEN_HI;
          end
          ST_LEN_HI: state_q <= ST_LEN_LO;
          ST_LEN_LO: begin
            state_q <= ST_DATA;
            cnt_q   <= '0;
            fin_q   <= 1'b0;
          end
          default: state_q <= ST_DATA;
        endcase
      end
    end
  end

  sha_out_slice #(.DAT_W(WORD_W + 5)) u_slice (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .in_vld  (ld_vld && !clr),
    .in_rdy  (ld_rdy),
    .in_dat  ({ld_dat, idx_q, ld_final}),
    .out_vld (blk_valid),
    .out_rdy (blk_ready),
    .out_dat ({blk_data, blk_idx, blk_final})
  );

endmodule
